// File: rtl/counter_write_arbiter.sv
// Two-client round-robin arbiter that read-modify-writes a shared 8-bit counter.
// Each grant drives one write port with value + delta, then pulses the owner's ack.
module counter_write_arbiter #(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req1,
  input  logic [7:0] delta1,
  output logic       ack1,
  input  logic       req2,
  input  logic [7:0] delta2,
  output logic       ack2,
  input  logic [7:0] value,
  output logic [7:0] wrdata1,
  output logic       wr1,
  output logic [7:0] wrdata2,
  output logic       wr2,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // owner/last: 0 = client 1, 1 = client 2
  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [8:0] sum9;
  logic [7:0] sum8;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req1 && req2) begin
          owner_d = ~last_q;
          state_d = GRANT;
        end else if (req1) begin
          owner_d = 1'b0;
          state_d = GRANT;
        end else if (req2) begin
          owner_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = ACK;
        last_d  = owner_q;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ninth bit of the sum is the carry that either wraps away or forces a clamp.
  always_comb begin
    sum9 = {1'b0, value} + {1'b0, (owner_q ? delta2 : delta1)};
    if (SATURATE && sum9[8]) begin
      sum8 = 8'hFF;
    end else begin
      sum8 = sum9[7:0];
    end
  end

  always_comb begin
    wr1     = (state_q == GRANT) && !owner_q;
    wr2     = (state_q == GRANT) && owner_q;
    wrdata1 = wr1 ? sum8 : 8'h00;
    wrdata2 = wr2 ? sum8 : 8'h00;
    ack1    = (state_q == ACK) && !owner_q;
    ack2    = (state_q == ACK) && owner_q;
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_counter_write_arbiter.sv
// Bench for counter_write_arbiter: wrapping and saturating instances share stimulus;
// a queue of expected writes is checked by a monitor as the grants appear.
module tb_counter_write_arbiter;

  logic       clk = 1'b0;
  logic       nrst;
  logic       req1, req2;
  logic [7:0] delta1, delta2;
  logic [7:0] cnt;
  logic       load_en;
  logic [7:0] load_val;

  logic       ack1, ack2, wr1, wr2, busy;
  logic [7:0] wrdata1, wrdata2;
  logic       s_ack1, s_ack2, s_wr1, s_wr2, s_busy;
  logic [7:0] s_wrdata1, s_wrdata2;

  typedef struct {
    bit         client;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  bit   exp_ack  = 1'b0;
  bit   ack_client;

  always #5 clk = ~clk;

  counter_write_arbiter #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .nrst(nrst),
    .req1(req1), .delta1(delta1), .ack1(ack1),
    .req2(req2), .delta2(delta2), .ack2(ack2),
    .value(cnt),
    .wrdata1(wrdata1), .wr1(wr1), .wrdata2(wrdata2), .wr2(wr2),
    .busy(busy)
  );

  counter_write_arbiter #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .nrst(nrst),
    .req1(req1), .delta1(delta1), .ack1(s_ack1),
    .req2(req2), .delta2(delta2), .ack2(s_ack2),
    .value(cnt),
    .wrdata1(s_wrdata1), .wr1(s_wr1), .wrdata2(s_wrdata2), .wr2(s_wr2),
    .busy(s_busy)
  );

  // Downstream shared counter, written by the wrapping instance.
  always @(posedge clk) begin
    if (load_en)  cnt <= load_val;
    else if (wr1) cnt <= wrdata1;
    else if (wr2) cnt <= wrdata2;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!nrst) begin
        n_checks++;
        if ({wr1, wr2, ack1, ack2, busy, s_wr1, s_wr2, s_ack1, s_ack2, s_busy} !== 10'd0 ||
            wrdata1 !== 8'd0 || wrdata2 !== 8'd0 || s_wrdata1 !== 8'd0 || s_wrdata2 !== 8'd0) begin
          n_fail++;
          $display("FAIL reset_outputs: wr=%b%b ack=%b%b busy=%b sat wr=%b%b ack=%b%b busy=%b, required all 0",
                   wr1, wr2, ack1, ack2, busy, s_wr1, s_wr2, s_ack1, s_ack2, s_busy);
        end
        exp_ack = 1'b0;
      end else begin
        n_checks++;
        if ((wr1 && wr2) || (s_wr1 && s_wr2)) begin
          n_fail++;
          $display("FAIL write_mutex: wr1=%b wr2=%b sat wr1=%b wr2=%b, required not both high",
                   wr1, wr2, s_wr1, s_wr2);
        end
        if (wr1 || wr2) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: wr1=%b wr2=%b, required no write", wr1, wr2);
          end else begin
            exp_t       e;
            logic [7:0] g0, g1, other;
            e     = sb.pop_front();
            g0    = wr2 ? wrdata2 : wrdata1;
            g1    = wr2 ? s_wrdata2 : s_wrdata1;
            other = wr2 ? wrdata1 : wrdata2;
            $display("txn client=%0d wrap_data=%0d sat_data=%0d", wr2 ? 2 : 1, g0, g1);
            if (wr2 !== e.client || g0 !== e.d0 || g1 !== e.d1 || other !== 8'd0 ||
                s_wr1 !== wr1 || s_wr2 !== wr2 || busy !== 1'b1) begin
              n_fail++;
              $display("FAIL grant_write: client=%0d data=%0d sat=%0d other=%0d busy=%b, required client=%0d data=%0d sat=%0d other=0 busy=1",
                       wr2 ? 2 : 1, g0, g1, other, busy, e.client ? 2 : 1, e.d0, e.d1);
            end
            exp_ack    = 1'b1;
            ack_client = e.client;
          end
        end else if (exp_ack) begin
          if (ack1 !== !ack_client || ack2 !== ack_client ||
              s_ack1 !== !ack_client || s_ack2 !== ack_client || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_pulse: ack1=%b ack2=%b sat ack1=%b ack2=%b busy=%b, required ack for client %0d and busy=1",
                     ack1, ack2, s_ack1, s_ack2, busy, ack_client ? 2 : 1);
          end
          exp_ack = 1'b0;
        end else begin
          if (ack1 || ack2 || s_ack1 || s_ack2) begin
            n_fail++;
            $display("FAIL spurious_ack: ack1=%b ack2=%b sat ack1=%b ack2=%b, required 0",
                     ack1, ack2, s_ack1, s_ack2);
          end
        end
      end
    end
  end

  function automatic logic [7:0] add8(input logic [7:0] v, input logic [7:0] d, input bit sat);
    int s;
    s = int'(v) + int'(d);
    if (sat && s > 255) return 8'hFF;
    return 8'(s);
  endfunction

  function automatic exp_t mk(input bit client, input logic [7:0] v, input logic [7:0] d);
    exp_t e;
    e.client = client;
    e.d0     = add8(v, d, 1'b0);
    e.d1     = add8(v, d, 1'b1);
    return e;
  endfunction

  task automatic load_cnt(input logic [7:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    #1 load_en = 1'b0;
  endtask

  // sel: 0 = wr1, 1 = wr2, 2 = ack1, 3 = ack2; returns at the negedge it was seen
  task automatic wait_for(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0:       ok = wr1;
        1:       ok = wr2;
        2:       ok = ack1;
        default: ok = ack2;
      endcase
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; req1 = 1'b0; req2 = 1'b0; delta1 = 8'd0; delta2 = 8'd0;
    load_en = 1'b1; load_val = 8'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr1, wr2, ack1, ack2, busy, s_busy} !== 6'd0 || wrdata1 !== 8'd0 || wrdata2 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: wr=%b%b ack=%b%b busy=%b sat busy=%b, required all 0",
               wr1, wr2, ack1, ack2, busy, s_busy);
    end
    mon_en = 1'b1;
    #1 nrst = 1'b1; load_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b, required 0", busy);
    end
    #1;
  endtask

  task automatic test_tie_after_reset();
    int acks;
    load_cnt(8'd0);
    delta1 = 8'd3; delta2 = 8'd7;
    sb.push_back(mk(1'b0, 8'd0, 8'd3));
    sb.push_back(mk(1'b1, 8'd3, 8'd7));
    sb.push_back(mk(1'b0, 8'd10, 8'd3));
    sb.push_back(mk(1'b1, 8'd13, 8'd7));
    req1 = 1'b1; req2 = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (ack1 || ack2) acks++;
    end
    n_checks++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL tie_acks: saw %0d acks, required 4", acks);
    end
    #1 req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_drain: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
    end
    #1;
  endtask

  task automatic test_single();
    load_cnt(8'd10);
    delta1 = 8'd5;
    sb.push_back(mk(1'b0, 8'd10, 8'd5));
    req1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr1 !== 1'b1 || wrdata1 !== 8'd15 || wr2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: wr1=%b wrdata1=%0d wr2=%b, required 1 15 0", wr1, wrdata1, wr2);
    end
    @(negedge clk);
    n_checks++;
    if (ack1 !== 1'b1 || wr1 !== 1'b0 || wr2 !== 1'b0 || ack2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack1=%b ack2=%b wr1=%b wr2=%b, required 1 0 0 0", ack1, ack2, wr1, wr2);
    end
    #1 req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ack1 !== 1'b0 || cnt !== 8'd15) begin
      n_fail++;
      $display("FAIL single_done: busy=%b ack1=%b cnt=%0d, required 0 0 15", busy, ack1, cnt);
    end
    #1;
  endtask

  task automatic test_wrap_clamp();
    bit ok;
    load_cnt(8'd250);
    delta2 = 8'd10;
    sb.push_back(mk(1'b1, 8'd250, 8'd10));
    req2 = 1'b1;
    wait_for(3, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_timeout: ack2 not seen, required within 30 cycles");
    end
    #1 req2 = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_req_while_busy();
    bit ok;
    load_cnt(8'd20);
    delta1 = 8'd4;
    sb.push_back(mk(1'b0, 8'd20, 8'd4));
    sb.push_back(mk(1'b1, 8'd24, 8'd6));
    req1 = 1'b1;
    wait_for(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL busy_grant1_timeout: wr1 not seen, required within 30 cycles");
    end
    #1 req2 = 1'b1; delta2 = 8'd6;
    wait_for(2, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL busy_ack1_timeout: ack1 not seen, required within 30 cycles");
    end
    #1 req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr2 !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle_gap: wr2=%b busy=%b, required 0 0", wr2, busy);
    end
    @(negedge clk);
    n_checks++;
    if (wr2 !== 1'b1 || wrdata2 !== 8'd30) begin
      n_fail++;
      $display("FAIL busy_grant2: wr2=%b wrdata2=%0d, required 1 30", wr2, wrdata2);
    end
    wait_for(3, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL busy_ack2_timeout: ack2 not seen, required within 30 cycles");
    end
    #1 req2 = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_zero_delta();
    bit ok;
    load_cnt(8'd77);
    delta1 = 8'd0;
    sb.push_back(mk(1'b0, 8'd77, 8'd0));
    req1 = 1'b1;
    wait_for(2, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL zero_timeout: ack1 not seen, required within 30 cycles");
    end
    #1 req1 = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset_in_grant();
    bit ok;
    int acks;
    load_cnt(8'd5);
    delta1 = 8'd1;
    sb.push_back(mk(1'b0, 8'd5, 8'd1));
    req1 = 1'b1;
    wait_for(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_grant_timeout: wr1 not seen, required within 30 cycles");
    end
    #1 nrst = 1'b0; req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ack1 !== 1'b0 || ack2 !== 1'b0 || s_busy !== 1'b0 || s_ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b ack1=%b ack2=%b sat busy=%b ack1=%b, required all 0",
               busy, ack1, ack2, s_busy, s_ack1);
    end
    #1 nrst = 1'b1;
    load_cnt(8'd40);
    delta1 = 8'd1; delta2 = 8'd2;
    sb.push_back(mk(1'b0, 8'd40, 8'd1));
    sb.push_back(mk(1'b1, 8'd41, 8'd2));
    req1 = 1'b1; req2 = 1'b1;
    acks = 0;
    for (int i = 0; i < 30 && acks < 2; i++) begin
      @(negedge clk);
      if (ack1 || ack2) acks++;
    end
    n_checks++;
    if (acks !== 2) begin
      n_fail++;
      $display("FAIL rst_tie_acks: saw %0d acks, required 2", acks);
    end
    #1 req1 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb.size() !== 0 || busy !== 1'b0 || cnt !== 8'd43) begin
      n_fail++;
      $display("FAIL rst_tie_drain: pending=%0d busy=%b cnt=%0d, required 0 0 43", sb.size(), busy, cnt);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie_after_reset();
    test_single();
    test_wrap_clamp();
    test_req_while_busy();
    test_zero_delta();
    test_reset_in_grant();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
